ysyx_040750_muldiv_ctrl: RTL and testbench
==========================================

Name: ysyx_040750_muldiv_ctrl

Overview:
EX-stage sequencer for the shared multicycle multiplier (booth serial) and radix-2 divider. It accepts one mul/div request from ID_EX and prepares sign/word-extended operands. It issues a one-cycle start pulse to the selected unit, waits for its done strobe, then formats and holds the result until EX_MEM accepts it. It also resolves RISC-V divide-by-zero and signed-overflow cases without starting the divider, and discards in-flight work on pipeline flush.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
DIV_BYPASS, 1, 1 = resolve div-by-zero/overflow locally; 0 = always use divider.

Ports:
I_sys_clk  in  1  clock, rising edge.
I_rst_n  in  1  reset, asynchronous, active-low.
I_req_valid  in  1  ID_EX holds a mul/div op.
O_req_ready  out  1  request accepted when valid & ready.
I_op_sel  in  4  one-hot {rem, div, mulh, mul}.
I_sext  in  2  [1] op1 signed, [0] op2 signed.
I_word_op  in  1  W-variant (32-bit operands and result).
I_op1, I_op2  in  64  raw operands.
I_flush  in  1  kill current op.
O_mul_start, O_div_start  out  1  one-cycle start pulses.
O_unit_op1, O_unit_op2  out  64  registered extended operands.
O_unit_sext  out  2  registered copy of I_sext.
I_mul_done  in  1  multiplier P valid (1 cycle).
I_mul_p  in  128  product {high, low}.
I_div_done  in  1  divider Q/R valid (1 cycle).
I_div_q, I_div_r  in  64  quotient, remainder.
O_result  out  64  formatted result.
O_result_valid  out  1  result held for EX_MEM.
I_result_ready  in  1  EX_MEM accepts result.
O_busy  out  1  state != IDLE.

Behaviour:
- Reset (async, I_rst_n=0): state IDLE; all registers 0; O_result_valid=0, starts=0, O_busy=0; O_req_ready=1 once reset deasserts.
- Operand extension at accept:
  - Sign bit = bit31 if I_word_op, else bit63; gated by the I_sext bit (0 when unsigned).
  - Word ops use {32{sign}, op[31:0]}; dword ops pass the operand through.
  - Extended operands are registered and held constant until the next accept.
- States IDLE, ISSUE, WAIT, DRAIN, HOLD.
- O_req_ready = IDLE, or HOLD & I_result_ready; forced 0 whenever I_flush=1.
- IDLE --accept--> ISSUE. Exception: a div/rem with a bypass case (DIV_BYPASS=1) goes straight to HOLD, result valid the next cycle.
- ISSUE: drive exactly one of O_mul_start/O_div_start for 1 cycle -> WAIT. A flush in ISSUE -> DRAIN.
- WAIT: on the matching done strobe, latch the result -> HOLD; O_result_valid=1 from the next cycle.
  - Done strobes for the non-selected unit are ignored.
  - Flush with no done -> DRAIN; flush together with done -> IDLE, result discarded.
- DRAIN: neither unit can abort, so wait for its done, discard -> IDLE. No new accept in DRAIN.
- HOLD: O_result stable and valid.
  - I_result_ready=1 -> IDLE, or ISSUE/HOLD if a new request is accepted in the same cycle (back-to-back).
  - Flush -> IDLE; valid drops the next cycle.
- Latency, accept to O_result_valid: unit latency + 2 cycles; bypass case 1 cycle.
- Result select: mul = P[63:0]; mulh = P[127:64]; div = Q; rem = R.
- Word ops: every result is sign-extended from bit 31, including divuw/remuw.
- Bypass, divisor extended = 0: div -> all ones; rem -> extended op1.
- Bypass, signed overflow (op1 = most negative for width, op2 = -1, both signed): div -> extended op1; rem -> 0.
- Invalid I_op_sel (not one-hot) at accept: treated as mul.
- Reset mid-operation: state returns to IDLE immediately; a later spurious done is ignored.

Test Plan:
- MUL: op1=7, op2=-3 (signed, signed) -> one O_mul_start pulse, O_unit_op2=0xFFFF_FFFF_FFFF_FFFD; after I_mul_done, O_result=0xFFFF_FFFF_FFFF_FFEB, valid until ready.
- DIVW: op1=0x1_8000_0000, op2=0x1_FFFF_FFFF, signed word -> bypass, no O_div_start, O_result=0xFFFF_FFFF_8000_0000 one cycle after accept; REMW -> 0.
- DIVU by zero: op2=0 -> O_result=0xFFFF_FFFF_FFFF_FFFF; REMU with op1=0x1234 -> 0x1234.
- Flush in WAIT: accept div, flush 3 cycles later -> DRAIN, O_req_ready=0 until I_div_done, no O_result_valid, then IDLE.
- Back-to-back: HOLD with I_result_ready=1 and new mulh request in the same cycle -> accepted, O_mul_start the next cycle, first result consumed exactly once.
- Async reset asserted in WAIT -> all outputs 0 without a clock edge; a subsequent I_div_done produces no result.

Source files
------------

// File: rtl/ysyx_040750_muldiv_ctrl.sv
// ysyx_040750_muldiv_ctrl: EX-stage sequencer for the shared serial multiplier and radix-2 divider.
// Extends operands, issues start pulses, formats and holds results; resolves div corner cases locally.
module ysyx_040750_muldiv_ctrl #(
  parameter int XLEN       = 64,
  parameter bit DIV_BYPASS = 1'b1
) (
  input  logic              I_sys_clk,
  input  logic              I_rst_n,
  input  logic              I_req_valid,
  output logic              O_req_ready,
  input  logic [3:0]        I_op_sel,
  input  logic [1:0]        I_sext,
  input  logic              I_word_op,
  input  logic [XLEN-1:0]   I_op1,
  input  logic [XLEN-1:0]   I_op2,
  input  logic              I_flush,
  output logic              O_mul_start,
  output logic              O_div_start,
  output logic [XLEN-1:0]   O_unit_op1,
  output logic [XLEN-1:0]   O_unit_op2,
  output logic [1:0]        O_unit_sext,
  input  logic              I_mul_done,
  input  logic [2*XLEN-1:0] I_mul_p,
  input  logic              I_div_done,
  input  logic [XLEN-1:0]   I_div_q,
  input  logic [XLEN-1:0]   I_div_r,
  output logic [XLEN-1:0]   O_result,
  output logic              O_result_valid,
  input  logic              I_result_ready,
  output logic              O_busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, HOLD} state_e;
  typedef enum logic [1:0] {K_MUL, K_MULH, K_DIV, K_REM} kind_e;

  state_e state_q, state_d;
  kind_e kind_q, kind_in;
  logic [XLEN-1:0] op1_q, op2_q, result_q, result_d;
  logic [1:0] sext_q;
  logic word_q;
  logic sign1, sign2, div_zero, div_ovf, bypass, accept, done;
  logic [XLEN-1:0] ext1, ext2, min_neg, byp_res, unit_res;

  function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] x);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  assign sign1 = I_sext[1] & (I_word_op ? I_op1[31] : I_op1[XLEN-1]);
  assign sign2 = I_sext[0] & (I_word_op ? I_op2[31] : I_op2[XLEN-1]);
  assign ext1 = I_word_op ? {{(XLEN-32){sign1}}, I_op1[31:0]} : I_op1;
  assign ext2 = I_word_op ? {{(XLEN-32){sign2}}, I_op2[31:0]} : I_op2;
  // Anything that is not exactly one-hot decodes as a plain mul.
  assign kind_in = I_op_sel == 4'b0010 ? K_MULH : I_op_sel == 4'b0100 ? K_DIV :
                   I_op_sel == 4'b1000 ? K_REM : K_MUL;
  assign min_neg = I_word_op ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = ext2 == '0;
  assign div_ovf = (&I_sext) & (ext1 == min_neg) & (&ext2);
  assign bypass = DIV_BYPASS & kind_in[1] & (div_zero | div_ovf);
  assign byp_res = kind_in == K_DIV ? (div_zero ? '1 : ext1) : (div_zero ? ext1 : '0);
  assign unit_res = kind_q == K_MUL ? I_mul_p[XLEN-1:0] : kind_q == K_MULH ? I_mul_p[2*XLEN-1:XLEN] :
                    kind_q == K_DIV ? I_div_q : I_div_r;
  assign done = kind_q[1] ? I_div_done : I_mul_done;

  assign O_req_ready = I_rst_n & ~I_flush & (state_q == IDLE | (state_q == HOLD & I_result_ready));
  assign accept = I_req_valid & O_req_ready;
  assign O_mul_start = state_q == ISSUE & ~kind_q[1];
  assign O_div_start = state_q == ISSUE & kind_q[1];
  assign O_unit_op1 = op1_q;
  assign O_unit_op2 = op2_q;
  assign O_unit_sext = sext_q;
  assign O_result = result_q;
  assign O_result_valid = state_q == HOLD;
  assign O_busy = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    result_d = result_q;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
          state_d = bypass ? HOLD : ISSUE;
          result_d = bypass ? fmt(I_word_op, byp_res) : result_q;
        end else if (state_q == HOLD && (I_flush || I_result_ready)) begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = I_flush ? DRAIN : WAIT;
      WAIT: begin
        if (done) begin
          state_d = I_flush ? IDLE : HOLD;
          result_d = fmt(word_q, unit_res);
        end else if (I_flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: state_d = done ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= IDLE;
      kind_q <= K_MUL;
      op1_q <= '0;
      op2_q <= '0;
      sext_q <= '0;
      word_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      if (accept) begin
        kind_q <= kind_in;
        op1_q <= ext1;
        op2_q <= ext2;
        sext_q <= I_sext;
        word_q <= I_word_op;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_040750_muldiv_ctrl.sv
// tb_ysyx_040750_muldiv_ctrl: directed and randomized checks of the mul/div sequencer
// against an arithmetic reference model; the bench also plays the multiplier and divider.
module tb_ysyx_040750_muldiv_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, word_op = 1'b0, flush = 1'b0;
  logic [3:0] op_sel = '0;
  logic [1:0] sext = '0, unit_sext;
  logic [63:0] op1 = '0, op2 = '0, unit_op1, unit_op2, result;
  logic mul_start, div_start, result_valid, busy;
  logic mul_done = 1'b0, div_done = 1'b0, result_ready = 1'b0;
  logic [127:0] mul_p = '0;
  logic [63:0] div_q = '0, div_r = '0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  ysyx_040750_muldiv_ctrl dut (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_req_valid(req_valid), .O_req_ready(req_ready),
    .I_op_sel(op_sel), .I_sext(sext), .I_word_op(word_op), .I_op1(op1), .I_op2(op2),
    .I_flush(flush), .O_mul_start(mul_start), .O_div_start(div_start),
    .O_unit_op1(unit_op1), .O_unit_op2(unit_op2), .O_unit_sext(unit_sext),
    .I_mul_done(mul_done), .I_mul_p(mul_p), .I_div_done(div_done), .I_div_q(div_q),
    .I_div_r(div_r), .O_result(result), .O_result_valid(result_valid),
    .I_result_ready(result_ready), .O_busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] sx32(input logic [63:0] x);
    logic signed [31:0] lo;
    lo = x[31:0];
    return 64'(lo);
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] x, input logic s, input logic w);
    if (!w) return x;
    return s ? sx32(x) : {32'h0, x[31:0]};
  endfunction

  task automatic model(input logic [3:0] sel, input logic [1:0] sx, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] ea, output logic [63:0] eb, output logic [63:0] res,
                       output logic byp, output logic [127:0] p,
                       output logic [63:0] q, output logic [63:0] r);
    int k;
    logic [127:0] wa, wb;
    logic sgn, ovf;
    k = $countones(sel) == 1 ? $clog2(sel) : 0;
    ea = ext(a, sx[1], w);
    eb = ext(b, sx[0], w);
    if (sx[1]) wa = {{64{ea[63]}}, ea}; else wa = {64'h0, ea};
    if (sx[0]) wb = {{64{eb[63]}}, eb}; else wb = {64'h0, eb};
    p = wa * wb;
    sgn = sx == 2'b11;
    ovf = sgn && eb == '1 && ea == (w ? sx32(64'h8000_0000) : 64'h8000_0000_0000_0000);
    if (eb == 0) begin q = '1; r = ea; end
    else if (ovf) begin q = ea; r = '0; end
    else if (sgn) begin q = $signed(ea) / $signed(eb); r = $signed(ea) % $signed(eb); end
    else begin q = ea / eb; r = ea % eb; end
    byp = k >= 2 && (eb == 0 || ovf);
    res = k == 0 ? p[63:0] : k == 1 ? p[127:64] : k == 2 ? q : r;
    if (w) res = sx32(res);
  endtask

  task automatic accept_req(input logic [3:0] sel, input logic [1:0] sx, input logic w,
                            input logic [63:0] a, input logic [63:0] b);
    req_valid = 1'b1; op_sel = sel; sext = sx; word_op = w; op1 = a; op2 = b;
    tick;
    req_valid = 1'b0; op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
  endtask

  task automatic do_txn(input logic [3:0] sel, input logic [1:0] sx, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input int lat, input int hold);
    logic [63:0] ea, eb, res, q, r;
    logic [127:0] p;
    logic byp, is_div;
    model(sel, sx, w, a, b, ea, eb, res, byp, p, q, r);
    is_div = $countones(sel) == 1 && sel[3:2] != 2'b00;
    #1 check("ready_idle", req_ready, 1);
    accept_req(sel, sx, w, a, b);
    check("uop1", unit_op1, ea);
    check("uop2", unit_op2, eb);
    check("usext", unit_sext, sx);
    if (byp) begin
      check("byp_valid", result_valid, 1);
      check("byp_start", {mul_start, div_start}, 0);
    end else begin
      check("start", {mul_start, div_start}, is_div ? 2'b01 : 2'b10);
      tick;
      check("one_pulse", {mul_start, div_start}, 0);
      for (int i = 1; i < lat; i++) begin
        if (i == 1) begin
          if (is_div) mul_done = 1'b1; else div_done = 1'b1;
          mul_p = {$urandom, $urandom, $urandom, $urandom}; div_q = {$urandom, $urandom};
        end
        tick;
        mul_done = 1'b0; div_done = 1'b0;
      end
      check("wait_valid", result_valid, 0);
      if (is_div) begin div_done = 1'b1; div_q = q; div_r = r; end
      else begin mul_done = 1'b1; mul_p = p; end
      tick;
      mul_done = 1'b0; div_done = 1'b0;
      mul_p = '0; div_q = '0; div_r = '0;
      check("valid", result_valid, 1);
    end
    check("result", result, res);
    for (int i = 0; i < hold; i++) begin
      tick;
      check("hold_valid", result_valid, 1);
      check("hold_result", result, res);
    end
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    check("consumed", result_valid, 0);
    check("idle", busy, 0);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return 64'h1;
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'hFFFF_FFFF_8000_0000;
      5: return {$urandom, $urandom} & 64'hFFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] ea, eb, res, q, r;
    logic [127:0] p;
    logic byp;
    #3;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_start", {mul_start, div_start}, 0);
    check("rst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_ready", req_ready, 1);

    do_txn(4'b0001, 2'b11, 1'b0, 64'd7, -64'sd3, 3, 2);
    do_txn(4'b0100, 2'b11, 1'b1, 64'h1_8000_0000, 64'h1_FFFF_FFFF, 1, 0);
    do_txn(4'b1000, 2'b11, 1'b1, 64'h1_8000_0000, 64'h1_FFFF_FFFF, 1, 1);
    do_txn(4'b0100, 2'b00, 1'b0, 64'd5, 64'd0, 1, 0);
    do_txn(4'b1000, 2'b00, 1'b0, 64'h1234, 64'd0, 1, 0);
    do_txn(4'b1000, 2'b00, 1'b1, 64'h8000_0001, 64'h1_0000_0000, 1, 0);
    do_txn(4'b0100, 2'b11, 1'b0, 64'h8000_0000_0000_0000, '1, 1, 0);
    do_txn(4'b0110, 2'b10, 1'b0, -64'sd9, 64'd4, 2, 0);

    // flush three cycles after accepting a div: drain without result
    accept_req(4'b0100, 2'b00, 1'b0, 64'd100, 64'd7);
    check("fw_start", div_start, 1);
    tick; tick; tick;
    flush = 1'b1;
    #1 check("fw_ready", req_ready, 0);
    tick;
    flush = 1'b0;
    req_valid = 1'b1; op_sel = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1 check("drain_ready", req_ready, 0);
      check("drain_busy", busy, 1);
      check("drain_valid", result_valid, 0);
      check("drain_start", {mul_start, div_start}, 0);
      tick;
    end
    div_done = 1'b1;
    tick;
    div_done = 1'b0; req_valid = 1'b0;
    check("drain_idle", busy, 0);
    check("drain_novalid", result_valid, 0);

    // flush in ISSUE still pulses start, then drains
    accept_req(4'b0001, 2'b00, 1'b0, 64'd3, 64'd4);
    flush = 1'b1;
    #1 check("fi_start", mul_start, 1);
    tick;
    flush = 1'b0;
    check("fi_busy", busy, 1);
    mul_done = 1'b1;
    tick;
    mul_done = 1'b0;
    check("fi_idle", busy, 0);
    check("fi_valid", result_valid, 0);

    // flush together with done in WAIT discards the result
    accept_req(4'b0001, 2'b00, 1'b0, 64'd3, 64'd4);
    tick;
    mul_done = 1'b1; flush = 1'b1;
    tick;
    mul_done = 1'b0; flush = 1'b0;
    check("fd_idle", busy, 0);
    check("fd_valid", result_valid, 0);

    // flush in HOLD drops valid
    accept_req(4'b0100, 2'b00, 1'b0, 64'd1, 64'd0);
    check("fh_valid", result_valid, 1);
    flush = 1'b1; result_ready = 1'b1; req_valid = 1'b1;
    #1 check("fh_ready", req_ready, 0);
    tick;
    flush = 1'b0; result_ready = 1'b0; req_valid = 1'b0;
    check("fh_drop", result_valid, 0);
    check("fh_idle", busy, 0);

    // back-to-back: consume a mul result while accepting a mulh
    accept_req(4'b0001, 2'b00, 1'b0, 64'd5, 64'd6);
    tick;
    mul_done = 1'b1; mul_p = 128'd30;
    tick;
    mul_done = 1'b0;
    check("b2b_first", result, 64'd30);
    model(4'b0010, 2'b11, 1'b0, -64'sd2, 64'd3, ea, eb, res, byp, p, q, r);
    result_ready = 1'b1; req_valid = 1'b1; op_sel = 4'b0010; sext = 2'b11; word_op = 1'b0;
    op1 = -64'sd2; op2 = 64'd3;
    #1 check("b2b_ready", req_ready, 1);
    tick;
    result_ready = 1'b0; req_valid = 1'b0;
    check("b2b_once", result_valid, 0);
    check("b2b_start", mul_start, 1);
    tick;
    mul_done = 1'b1; mul_p = p;
    tick;
    mul_done = 1'b0;
    check("b2b_valid", result_valid, 1);
    check("b2b_result", result, res);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;

    // asynchronous reset while waiting on the divider
    accept_req(4'b0100, 2'b00, 1'b0, 64'd100, 64'd7);
    tick;
    #1 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_valid", result_valid, 0);
    check("ar_start", {mul_start, div_start}, 0);
    check("ar_result", result, 0);
    check("ar_uop1", unit_op1, 0);
    check("ar_uop2", unit_op2, 0);
    tick;
    rst_n = 1'b1;
    div_done = 1'b1; div_q = 64'd14;
    tick;
    div_done = 1'b0;
    check("ar_spurious_valid", result_valid, 0);
    check("ar_spurious_busy", busy, 0);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] sel;
      logic [1:0] sx;
      sel = $urandom_range(0, 9) == 0 ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      sx = 2'($urandom);
      if (sel[3:2] != 2'b00 && $urandom_range(0, 3) != 0) sx = {2{sx[0]}};
      do_txn(sel, sx, 1'($urandom), pick(), pick(), $urandom_range(1, 6), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
